// File: rtl/piso_serializer_if.sv
// Bundle of parallel-in handshake and serial-out signals for piso_serializer.
//   master : producer/consumer side (drives din*, din_valid, bit_en)
//   slave  : serializer side (drives din_ready, dout, dout_valid, busy, done)
interface piso_serializer_if #(
  parameter int DATA_W = 8
);
  localparam int LEN_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] din;
  logic [LEN_W-1:0]  din_len;
  logic              din_msb_first;
  logic              din_valid;
  logic              din_ready;
  logic              bit_en;
  logic              dout;
  logic              dout_valid;
  logic              busy;
  logic              done;

  modport master (
    output din, din_len, din_msb_first, din_valid, bit_en,
    input  din_ready, dout, dout_valid, busy, done
  );

  modport slave (
    input  din, din_len, din_msb_first, din_valid, bit_en,
    output din_ready, dout, dout_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word holding buffer.
// Words (up to DATA_W bits, selectable length and bit order) are accepted
// over a valid/ready handshake and shifted out one bit per bit_en strobe.
// A buffered word follows the current frame with no idle bit in between.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : piso_serializer_if slave modport
//              din/din_len/din_msb_first/din_valid -> word offer
//              din_ready                           <- buffer empty
//              bit_en                              -> bit-rate strobe
//              dout/dout_valid                     <- registered serial bit
//              busy                                <- frame shifting or buffered
//              done                                <- last bit of frame driven
module piso_serializer #(
  parameter int   DATA_W     = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input logic                clk,
  input logic                reset_n,
  piso_serializer_if.slave   bus
);
  localparam int LEN_W = $clog2(DATA_W + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);

  // Zero or out-of-range lengths mean a full-width frame.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    if (len == '0 || len > FULL_LEN) return FULL_LEN;
    return len;
  endfunction

  // MSB-first frames are left-aligned so bit L-1 sits at the top and the
  // register always shifts out of its MSB; LSB-first frames shift out of
  // bit 0, so unused upper bits are simply never reached.
  function automatic logic [DATA_W-1:0] align(input logic [DATA_W-1:0] word,
                                              input logic [LEN_W-1:0]  len,
                                              input logic              msb);
    if (msb) return word << (FULL_LEN - len);
    return word;
  endfunction

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] hold_word_q, hold_word_d;
  logic [LEN_W-1:0]  hold_len_q, hold_len_d;
  logic              hold_msb_q, hold_msb_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              msb_q, msb_d;
  logic              dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              done_q, done_d;
  logic              load;

  always_comb begin
    state_d      = state_q;
    hold_word_d  = hold_word_q;
    hold_len_d   = hold_len_q;
    hold_msb_d   = hold_msb_q;
    hold_full_d  = hold_full_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    msb_d        = msb_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    done_d       = 1'b0;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        // The transfer edge emits nothing, so bit_en is ignored on it.
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = SHIFT;
        end else if (bus.bit_en) begin
          dout_d       = IDLE_LEVEL;
          dout_valid_d = 1'b0;
        end
      end
      SHIFT: begin
        if (bus.bit_en) begin
          dout_d       = msb_q ? shreg_q[DATA_W-1] : shreg_q[0];
          dout_valid_d = 1'b1;
          cnt_d        = cnt_q - LEN_W'(1);
          shreg_d      = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
          if (cnt_q == LEN_W'(1)) begin
            done_d = 1'b1;
            // Chain straight into the buffered word to avoid a gap bit.
            if (hold_full_q) load = 1'b1;
            else             state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shreg_d     = align(hold_word_q, hold_len_q, hold_msb_q);
      cnt_d       = hold_len_q;
      msb_d       = hold_msb_q;
      hold_full_d = 1'b0;
    end

    // Ready is the registered empty flag, so acceptance never coincides
    // with the buffer emptying.
    if (!hold_full_q && bus.din_valid) begin
      hold_word_d = bus.din;
      hold_len_d  = eff_len(bus.din_len);
      hold_msb_d  = bus.din_msb_first;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_word_q  <= '0;
      hold_len_q   <= '0;
      hold_msb_q   <= 1'b0;
      hold_full_q  <= 1'b0;
      shreg_q      <= '0;
      cnt_q        <= '0;
      msb_q        <= 1'b0;
      dout_q       <= IDLE_LEVEL;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_word_q  <= hold_word_d;
      hold_len_q   <= hold_len_d;
      hold_msb_q   <= hold_msb_d;
      hold_full_q  <= hold_full_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      msb_q        <= msb_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      done_q       <= done_d;
    end
  end

  assign bus.din_ready  = ~hold_full_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q == SHIFT) || hold_full_q;
endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;
  logic clk;
  logic reset_n;

  piso_serializer_if #(.DATA_W(8)) bus ();

  piso_serializer #(.DATA_W(8), .IDLE_LEVEL(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic b;
    logic last;
  } exp_t;

  exp_t exp_q[$];
  int   done_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   run = 0;
  int   max_run = 0;
  int   en_mode = 0;
  logic en_seen = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // bit_en generator: mode 0 = off, N = one strobe every N cycles.
  initial begin
    int k;
    k = 0;
    bus.bit_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      bus.bit_en = (en_mode != 0) && (k % en_mode == 0);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      en_seen = bus.bit_en;
    end
  end

  // Monitor: every strobe that produces a frame bit pops the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        if (en_seen && bus.dout_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_bit", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("dout", bus.dout, e.b);
            check("done_on_bit", bus.done, e.last);
          end
          run++;
          if (run > max_run) max_run = run;
        end else begin
          if (en_seen) run = 0;
          check("done_no_bit", bus.done, 1'b0);
        end
        if (bus.done) done_cyc.push_back(cyc);
      end
    end
  end

  // Offer a word and keep din_valid high; expected bits are given by hand.
  task automatic send(input logic [7:0] w, input logic [3:0] len, input logic m,
                      input string bits, output int waited);
    exp_t e;
    bus.din           = w;
    bus.din_len       = len;
    bus.din_msb_first = m;
    bus.din_valid     = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.din_ready) break;
      waited++;
      if (waited > 500) begin
        check("accept_timeout", 1'b1, 1'b0);
        break;
      end
    end
    for (int i = 0; i < bits.len(); i++) begin
      e.b    = (bits[i] == "1");
      e.last = (i == bits.len() - 1);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic go_idle();
    en_mode = 1;
    repeat (3) @(negedge clk);
    #1;
    check("idle_dout", bus.dout, 1'b1);
    check("idle_valid", bus.dout_valid, 1'b0);
    check("idle_busy", bus.busy, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w1, w2, w3, nd;
    reset_n           = 1'b0;
    bus.din           = '0;
    bus.din_len       = '0;
    bus.din_msb_first = 1'b0;
    bus.din_valid     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", bus.dout, 1'b1);
    check("rst_valid", bus.dout_valid, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ready", bus.din_ready, 1'b1);
    reset_n = 1'b1;

    // Basic MSB-first full-width frame.
    en_mode = 4;
    @(posedge clk); #1;
    send(8'hA5, 4'd0, 1'b1, "10100101", w1);
    bus.din_valid = 1'b0;
    wait_drain(400);
    @(negedge clk); #1;
    check("busy_after_frame", bus.busy, 1'b0);
    go_idle();

    // Short LSB-first frame; upper bits must not appear.
    en_mode = 2;
    @(posedge clk); #1;
    send(8'hF2, 4'd3, 1'b0, "010", w1);
    bus.din_valid = 1'b0;
    wait_drain(200);
    go_idle();

    // Back-to-back with bit_en held high.
    max_run = 0;
    run = 0;
    done_cyc.delete();
    @(posedge clk); #1;
    send(8'h81, 4'd8, 1'b1, "10000001", w1);
    send(8'h7E, 4'd8, 1'b1, "01111110", w2);
    bus.din_valid = 1'b0;
    wait_drain(200);
    go_idle();
    check("b2b_run", max_run, 16);
    check("b2b_done_cnt", done_cyc.size(), 2);
    if (done_cyc.size() == 2) check("b2b_done_gap", done_cyc[1] - done_cyc[0], 8);

    // Backpressure: three words with din_valid held high.
    en_mode = 3;
    @(posedge clk); #1;
    send(8'h96, 4'd5, 1'b0, "01101", w1);
    send(8'hE7, 4'd4, 1'b1, "0111", w2);
    send(8'h3C, 4'd8, 1'b1, "00111100", w3);
    bus.din_valid = 1'b0;
    check("bp_first_wait", w1, 0);
    check("bp_second_stalled", w2 >= 1, 1'b1);
    check("bp_third_stalled", w3 >= 5, 1'b1);
    wait_drain(600);
    go_idle();

    // Over-long length clamps to DATA_W.
    en_mode = 2;
    @(posedge clk); #1;
    send(8'h4D, 4'd15, 1'b1, "01001101", w1);
    bus.din_valid = 1'b0;
    wait_drain(300);
    go_idle();

    // Reset in the middle of a frame.
    en_mode = 2;
    nd = done_cyc.size();
    @(posedge clk); #1;
    send(8'hC3, 4'd0, 1'b1, "11000011", w1);
    bus.din_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (exp_q.size() > 5 && n < 200) begin
        @(posedge clk);
        n++;
      end
      check("mid_frame_timeout", exp_q.size() <= 5, 1'b1);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_dout", bus.dout, 1'b1);
    check("mid_rst_valid", bus.dout_valid, 1'b0);
    check("mid_rst_done", bus.done, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_ready", bus.din_ready, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_rst_no_done", done_cyc.size(), nd);
    check("mid_rst_stay_idle", bus.busy, 1'b0);
    @(posedge clk); #1;
    send(8'h35, 4'd6, 1'b0, "101011", w1);
    bus.din_valid = 1'b0;
    wait_drain(300);
    check("post_rst_done", done_cyc.size(), nd + 1);
    go_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
